// File: rtl/implication_queue.sv
// ---------------------------------------------------------------------------
// implication_queue
//
// This block buffers the variable assignments implied during Boolean
// constraint propagation. It passes them one at a time to the
// variable-assignment stage.
//
// Each variable has a pending bit and a pending value. With these, every
// offered implication is classified in the same cycle it arrives:
//   - new:       the implication is enqueued.
//   - duplicate: the implication is accepted and dropped.
//   - conflict:  the implication is accepted, not enqueued, and the queue
//                stops in CONFLICT until the next flush or reset.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset; clears all state
//   flush        backtrack; empties the queue and clears pending/conflict
//   in_valid     implication offered by a unit clause evaluator
//   in_var       implied variable ID
//   in_val       implied value
//   in_ready     queue accepts the offered implication this cycle
//   out_valid    head entry available
//   out_var      head variable ID (0 when the queue is empty)
//   out_val      head value (0 when the queue is empty)
//   out_ready    consumer takes the head this cycle
//   conflict     sticky conflict flag
//   conflict_var variable that caused the conflict
//   count        number of queued entries
// ---------------------------------------------------------------------------
module implication_queue #(
    parameter int NUM_VARIABLE   = 128,
    parameter int VARIABLE_INDEX = 6,
    parameter int DEPTH          = 16,
    parameter int COUNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [VARIABLE_INDEX:0]   in_var,
    input  logic                      in_val,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [VARIABLE_INDEX:0]   out_var,
    output logic                      out_val,
    input  logic                      out_ready,
    output logic                      conflict,
    output logic [VARIABLE_INDEX:0]   conflict_var,
    output logic [COUNT_W-1:0]        count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

    typedef enum logic {
        RUN      = 1'b0,
        CONFLICT = 1'b1
    } state_t;

    state_t                     state;
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W-1:0]           wr_ptr;
    logic [NUM_VARIABLE-1:0]    pending;
    logic [NUM_VARIABLE-1:0]    pend_val;

    // Each FIFO entry stores {variable, value}, with the value in bit 0.
    logic [VARIABLE_INDEX+1:0]  fifo_mem [DEPTH];
    logic [VARIABLE_INDEX+1:0]  head_entry;
    logic [VARIABLE_INDEX:0]    head_var;

    logic push;
    logic pop;
    logic push_new;
    logic push_conflict;
    logic count_zero;

    assign count_zero = (count == '0);
    assign head_entry = fifo_mem[rd_ptr];
    assign head_var   = head_entry[VARIABLE_INDEX+1:1];

    // Both handshake signals depend only on registered state. This keeps
    // out_ready from reaching in_ready combinationally. Because of that, a
    // full queue refuses a push even in a cycle where it pops.
    assign in_ready  = !reset && (state == RUN) && (count != FULL_COUNT);
    assign out_valid = !reset && (state == RUN) && !count_zero;

    // The head outputs are forced to 0 when the queue is empty, so
    // consumers never see stale storage.
    assign out_var = count_zero ? '0 : head_var;
    assign out_val = count_zero ? 1'b0 : head_entry[0];

    // Flush overrides both handshakes.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // A push is classified against the pending state from the start of the
    // cycle. So a push that hits the head being popped in the same cycle is
    // still treated as a duplicate or a conflict, never as a new entry.
    assign push_new      = push && !pending[in_var];
    assign push_conflict = push && pending[in_var] && (pend_val[in_var] != in_val);

    // The storage needs no reset, because count and pending decide what is
    // valid.
    always_ff @(posedge clk) begin
        if (push_new) begin
            fifo_mem[wr_ptr] <= {in_var, in_val};
        end
    end

    // Control state: pointers, count, per-variable bitmaps and conflict.
    // A new push and a pop in the same cycle always target different
    // variables: the head variable is still pending, so a push of it
    // cannot be new.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state        <= RUN;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            pending      <= '0;
            pend_val     <= '0;
            conflict     <= 1'b0;
            conflict_var <= '0;
        end else begin
            if (pop) begin
                rd_ptr            <= rd_ptr + 1'b1;
                pending[head_var] <= 1'b0;
            end
            if (push_new) begin
                wr_ptr           <= wr_ptr + 1'b1;
                pending[in_var]  <= 1'b1;
                pend_val[in_var] <= in_val;
            end
            if (push_conflict) begin
                state        <= CONFLICT;
                conflict     <= 1'b1;
                conflict_var <= in_var;
            end
            case ({push_new, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
